pipe_controller_hz: RTL and testbench
=====================================

Name: pipe_controller_hz

Overview:
- Parametrised successor to the 5-stage MIPS pipeline controller.
- Decodes opcode/funct in D and carries control bits through the D/E, E/M and M/WB registers.
- Adds hazard support: HOLD freezes the pipe, FLUSH_E inserts a bubble in E, and a taken branch squashes E and M.
- Extends the decode set with J, ANDI and ORI, and adds a saturating illegal-instruction counter in WB.

Parameters:
- ALUCTRL_W, 3, ALUCONTROL output width. Must be >=3; extra MSBs are zero.
- CNT_W, 8, width of the illegal-instruction counter.

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- opcode  in  6  instruction[31:26] in D
- funct  in  6  instruction[5:0] in D
- ZERO_M  in  1  ALU zero flag of the instruction in M
- HOLD  in  1  freeze all pipeline registers and the counter
- FLUSH_E  in  1  load bubble into D/E (load-use stall from hazard unit)
- JUMP_D  out  1  combinational: D holds J
- REGWRITE_E, MEMTOREG_E, MEMWRITE_E, BRANCH_E, ALUSRC_E, REGDST_E, ZEROEXT_E  out  1 each  E-stage controls
- ALUCONTROL_E  out  ALUCTRL_W  E-stage ALU op
- REGWRITE_M, MEMTOREG_M, MEMWRITE_M, BRANCH_M  out  1 each  M-stage controls
- PCSRC_M  out  1  combinational taken-branch
- REGWRITE_WB, MEMTOREG_WB  out  1 each  WB-stage controls
- ILL_CNT  out  CNT_W  saturating count of illegal instructions retired
- ILL_STICKY  out  1  set on first illegal retire; cleared only by RESET

Behaviour:
- Reset: every registered output, all internal stage bits and ILL_CNT are 0 on the first edge with RESET=1. RESET overrides HOLD and all flushes.

Decode (D, combinational). Fields are RW/MR/MW/BR/AS/RD/ZX/aluctl/ILL:
- R-type 000000: 1/0/0/0/0/1/0/funct/0.
- LW 100011: 1/1/0/0/1/0/0/add.
- SW 101011: 0/0/1/0/1/0/0/add.
- BEQ 000100: 0/0/0/1/0/0/0/sub.
- ADDI 001000: 1/0/0/0/1/0/0/add.
- ANDI 001100: 1/0/0/0/1/0/1/and.
- ORI 001101: 1/0/0/0/1/0/1/or.
- J 000010: all zero, JUMP_D=1.
- Any other opcode: all zero, ILL=1.
- funct map: 100000 add=010, 100010 sub=110, 100100 and=000, 100101 or=001, 101010 slt=111.
- Unknown funct on R-type: ALUCONTROL=000, RW forced 0, ILL=1. Never X.

Pipeline:
- One register per stage. Latency D→E 1 cycle, →M 2 cycles, →WB 3 cycles.
- ILL bit travels with each instruction to WB.
- PCSRC_M = BRANCH_M & ZERO_M.

Edge priority: RESET > HOLD > branch flush > FLUSH_E.
- HOLD=1: all stage registers, ILL_CNT and ILL_STICKY keep their values.
- PCSRC_M=1 and HOLD=0: D/E and E/M load all-zero bubbles; M/WB loads M normally.
- FLUSH_E=1, no branch flush, HOLD=0: D/E loads a bubble; E/M and M/WB advance normally.
- Bubbles carry ILL=0 and never count.

Counter:
- On an edge with HOLD=0 and ILL_WB=1: ILL_CNT increments, saturating at 2^CNT_W-1, and ILL_STICKY is set.

Optional Feature:
- Macro: PIPE_CTRL_BNE_EN.
- Defined:
  - Opcode 000101 decodes as BNE: same controls as BEQ plus an NE bit piped to M.
  - PCSRC_M = BRANCH_M & (ZERO_M ^ NE_M).
- Undefined:
  - No NE bit exists.
  - Opcode 000101 is illegal.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - opcode and funct localparams;
  - ALU op encodings;
  - packed struct ctrl_t {regwrite, memtoreg, memwrite, branch, alusrc, regdst, zeroext, ill, [ne], alucontrol};
  - constant CTRL_BUBBLE = '0.
- Natural sub-module: pipe_ctrl_decode, the combinational opcode/funct → ctrl_t decoder.
- Stage registers are instantiated inline, with enable and clear.

Test Plan:
- Reset: RESET=1 for 2 cycles mid-stream → all outputs 0 and ILL_CNT=0 on the next edge.
- Pipeline: issue LW then ADD (funct 100000), HOLD=0 → ALUCONTROL_E=010 with MEMTOREG_E=1 at cycle 1; REGWRITE_WB=1, MEMTOREG_WB=1 at cycle 3; ADD arrives one cycle later with MEMTOREG_WB=0.
- Branch: BEQ followed by ADDI and SW, ZERO_M=1 when BEQ is in M → PCSRC_M=1; next cycle REGWRITE_M=0 and MEMWRITE_E/M=0 (ADDI and SW squashed).
- Priority: FLUSH_E=1 with HOLD=1 → registers unchanged; then HOLD=0 → bubble in E, the M contents advance to WB.
- Illegal counter: CNT_W=2, four illegal opcodes (e.g. 111111) plus one R-type with funct 000001 → ILL_CNT saturates at 3, ILL_STICKY=1, and the R-type has REGWRITE_WB=0. A bubble with ILL=0 leaves the count unchanged.
- Optional feature: with PIPE_CTRL_BNE_EN defined, BNE with ZERO_M=0 → PCSRC_M=1. Without it → ILL_CNT increments and PCSRC_M stays 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
//
// Shared definitions for the hazard-aware 5-stage MIPS pipeline controller:
//   - opcode / funct field encodings recognised by the decoder
//   - ALU operation encodings driven on ALUCONTROL
//   - per-stage control bundles (ctrl_t for D/E, ctrl_m_t for E/M,
//     ctrl_wb_t for M/WB) and their all-zero bubble constants
//   - decode_funct(), the R-type funct -> ALU op lookup
//
// Build option:
//   PIPE_CTRL_BNE_EN  adds the BNE opcode and an NE bit that travels with
//                     the instruction into the M stage.
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    // Primary opcodes, instruction[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef PIPE_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    // R-type function codes, instruction[5:0]
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation encodings (native 3-bit form)
    localparam int         ALUOP_W = 3;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Full control word produced in D and held in the D/E register
    typedef struct packed {
        logic               regwrite;
        logic               memtoreg;
        logic               memwrite;
        logic               branch;
        logic               alusrc;
        logic               regdst;
        logic               zeroext;
        logic               ill;
`ifdef PIPE_CTRL_BNE_EN
        logic               ne;
`endif
        logic [ALUOP_W-1:0] alucontrol;
    } ctrl_t;

    // Subset still needed once the instruction has left E
    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic memwrite;
        logic branch;
        logic ill;
`ifdef PIPE_CTRL_BNE_EN
        logic ne;
`endif
    } ctrl_m_t;

    // Subset still needed in write-back
    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic ill;
    } ctrl_wb_t;

    // A bubble is an all-zero control word: writes nothing, never illegal
    localparam ctrl_t    CTRL_BUBBLE    = '0;
    localparam ctrl_m_t  CTRL_M_BUBBLE  = '0;
    localparam ctrl_wb_t CTRL_WB_BUBBLE = '0;

    // Maps an R-type funct to {valid, aluop}. Unknown codes return
    // valid=0 with the AND encoding (000) so the output is never X.
    function automatic logic [ALUOP_W:0] decode_funct(input logic [5:0] fn);
        case (fn)
            FN_ADD:  return {1'b1, ALU_ADD};
            FN_SUB:  return {1'b1, ALU_SUB};
            FN_AND:  return {1'b1, ALU_AND};
            FN_OR:   return {1'b1, ALU_OR};
            FN_SLT:  return {1'b1, ALU_SLT};
            default: return {1'b0, ALU_AND};
        endcase
    endfunction

endpackage

// File: rtl/pipe_ctrl_decode.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_decode
//
// Purely combinational decode-stage control generator.
//
// Ports:
//   opcode_i  [5:0]  instruction[31:26] in D
//   funct_i   [5:0]  instruction[5:0] in D (only meaningful for R-type)
//   ctrl_o    ctrl_t full control word for the instruction in D
//   jump_o           D holds an unconditional J
//
// Build option:
//   PIPE_CTRL_BNE_EN  decodes opcode 000101 as BNE instead of illegal.
// ---------------------------------------------------------------------------
module pipe_ctrl_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output ctrl_t      ctrl_o,
    output logic       jump_o
);

    logic               functValid;
    logic [ALUOP_W-1:0] functAlu;

    // The funct lookup runs unconditionally; only the R-type arm uses it.
    assign {functValid, functAlu} = decode_funct(funct_i);

    // Every arm starts from a bubble so unlisted fields stay zero. An
    // R-type with an unknown funct keeps its register-destination select
    // but is stopped from writing and is flagged illegal so it counts at
    // retirement. Unrecognised opcodes decode to an illegal bubble.
    always_comb begin
        ctrl_o = CTRL_BUBBLE;
        jump_o = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                ctrl_o.regdst = 1'b1;
                if (functValid) begin
                    ctrl_o.regwrite   = 1'b1;
                    ctrl_o.alucontrol = functAlu;
                end else begin
                    ctrl_o.ill        = 1'b1;
                end
            end
            OP_LW: begin
                ctrl_o.regwrite   = 1'b1;
                ctrl_o.memtoreg   = 1'b1;
                ctrl_o.alusrc     = 1'b1;
                ctrl_o.alucontrol = ALU_ADD;
            end
            OP_SW: begin
                ctrl_o.memwrite   = 1'b1;
                ctrl_o.alusrc     = 1'b1;
                ctrl_o.alucontrol = ALU_ADD;
            end
            OP_BEQ: begin
                ctrl_o.branch     = 1'b1;
                ctrl_o.alucontrol = ALU_SUB;
            end
`ifdef PIPE_CTRL_BNE_EN
            OP_BNE: begin
                ctrl_o.branch     = 1'b1;
                ctrl_o.ne         = 1'b1;
                ctrl_o.alucontrol = ALU_SUB;
            end
`endif
            OP_ADDI: begin
                ctrl_o.regwrite   = 1'b1;
                ctrl_o.alusrc     = 1'b1;
                ctrl_o.alucontrol = ALU_ADD;
            end
            OP_ANDI: begin
                ctrl_o.regwrite   = 1'b1;
                ctrl_o.alusrc     = 1'b1;
                ctrl_o.zeroext    = 1'b1;
                ctrl_o.alucontrol = ALU_AND;
            end
            OP_ORI: begin
                ctrl_o.regwrite   = 1'b1;
                ctrl_o.alusrc     = 1'b1;
                ctrl_o.zeroext    = 1'b1;
                ctrl_o.alucontrol = ALU_OR;
            end
            OP_J: begin
                jump_o = 1'b1;
            end
            default: begin
                ctrl_o.ill = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/pipe_controller_hz.sv
// ---------------------------------------------------------------------------
// pipe_controller_hz
//
// 5-stage MIPS pipeline controller with hazard support. Control bits are
// decoded in D and carried through the D/E, E/M and M/WB registers.
// HOLD freezes the whole pipe, FLUSH_E bubbles the D/E register, and a
// taken branch in M bubbles both D/E and E/M. Illegal instructions are
// counted (saturating) when they retire from WB.
//
// Parameters:
//   ALUCTRL_W  width of ALUCONTROL_E (>=3, extra MSBs are zero)
//   CNT_W      width of the illegal-instruction counter
//
// Ports:
//   CLK, RESET                 clock, synchronous active-high reset
//   opcode, funct              instruction fields in D
//   ZERO_M                     ALU zero flag of the instruction in M
//   HOLD                       freeze all pipeline state
//   FLUSH_E                    load a bubble into D/E
//   JUMP_D                     combinational: D holds J
//   *_E                        E-stage controls (registered)
//   *_M                        M-stage controls (registered)
//   PCSRC_M                    combinational taken-branch
//   *_WB                       WB-stage controls (registered)
//   ILL_CNT, ILL_STICKY        illegal-retire count and sticky flag
//
// Build option:
//   PIPE_CTRL_BNE_EN  enables BNE; PCSRC_M = BRANCH_M & (ZERO_M ^ NE_M).
// ---------------------------------------------------------------------------
module pipe_controller_hz
    import pipe_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3,
    parameter int CNT_W     = 8
)
(
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 ZERO_M,
    input  logic                 HOLD,
    input  logic                 FLUSH_E,
    output logic                 JUMP_D,
    output logic                 REGWRITE_E,
    output logic                 MEMTOREG_E,
    output logic                 MEMWRITE_E,
    output logic                 BRANCH_E,
    output logic                 ALUSRC_E,
    output logic                 REGDST_E,
    output logic                 ZEROEXT_E,
    output logic [ALUCTRL_W-1:0] ALUCONTROL_E,
    output logic                 REGWRITE_M,
    output logic                 MEMTOREG_M,
    output logic                 MEMWRITE_M,
    output logic                 BRANCH_M,
    output logic                 PCSRC_M,
    output logic                 REGWRITE_WB,
    output logic                 MEMTOREG_WB,
    output logic [CNT_W-1:0]     ILL_CNT,
    output logic                 ILL_STICKY
);

    ctrl_t      ctrlD;
    ctrl_t      ctrlE_q,  ctrlE_d;
    ctrl_m_t    ctrlM_q,  ctrlM_d;
    ctrl_wb_t   ctrlWb_q, ctrlWb_d;
    ctrl_m_t    eToM;
    ctrl_wb_t   mToWb;
    logic [CNT_W-1:0] illCnt_q, illCnt_d;
    logic             illSticky_q, illSticky_d;
    logic             branchTaken;

    pipe_ctrl_decode uDecode (
        .opcode_i (opcode),
        .funct_i  (funct),
        .ctrl_o   (ctrlD),
        .jump_o   (JUMP_D)
    );

    // Narrow the wide stage words down to what the next stage still needs.
    always_comb begin
        eToM          = CTRL_M_BUBBLE;
        eToM.regwrite = ctrlE_q.regwrite;
        eToM.memtoreg = ctrlE_q.memtoreg;
        eToM.memwrite = ctrlE_q.memwrite;
        eToM.branch   = ctrlE_q.branch;
        eToM.ill      = ctrlE_q.ill;
`ifdef PIPE_CTRL_BNE_EN
        eToM.ne       = ctrlE_q.ne;
`endif
        mToWb          = CTRL_WB_BUBBLE;
        mToWb.regwrite = ctrlM_q.regwrite;
        mToWb.memtoreg = ctrlM_q.memtoreg;
        mToWb.ill      = ctrlM_q.ill;
    end

    // The branch decision is resolved in M from the registered branch bit
    // and the live ALU zero flag; BNE inverts the sense of the flag.
`ifdef PIPE_CTRL_BNE_EN
    assign branchTaken = ctrlM_q.branch & (ZERO_M ^ ctrlM_q.ne);
`else
    assign branchTaken = ctrlM_q.branch & ZERO_M;
`endif

    // Next-state selection. HOLD keeps everything, including the counter.
    // A taken branch squashes the two younger instructions (in D and E);
    // the branch itself still advances to WB. Without a branch, FLUSH_E
    // only replaces the instruction entering E, letting older ones move on.
    // The counter looks at the instruction currently sitting in WB, so an
    // instruction is counted on the edge that retires it.
    always_comb begin
        ctrlE_d     = ctrlE_q;
        ctrlM_d     = ctrlM_q;
        ctrlWb_d    = ctrlWb_q;
        illCnt_d    = illCnt_q;
        illSticky_d = illSticky_q;
        if (!HOLD) begin
            if (branchTaken) begin
                ctrlE_d = CTRL_BUBBLE;
                ctrlM_d = CTRL_M_BUBBLE;
            end else if (FLUSH_E) begin
                ctrlE_d = CTRL_BUBBLE;
                ctrlM_d = eToM;
            end else begin
                ctrlE_d = ctrlD;
                ctrlM_d = eToM;
            end
            ctrlWb_d = mToWb;
            if (ctrlWb_q.ill) begin
                illSticky_d = 1'b1;
                if (illCnt_q != {CNT_W{1'b1}}) begin
                    illCnt_d = illCnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Stage registers and counter. RESET wins over HOLD and every flush.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ctrlE_q     <= CTRL_BUBBLE;
            ctrlM_q     <= CTRL_M_BUBBLE;
            ctrlWb_q    <= CTRL_WB_BUBBLE;
            illCnt_q    <= '0;
            illSticky_q <= 1'b0;
        end else begin
            ctrlE_q     <= ctrlE_d;
            ctrlM_q     <= ctrlM_d;
            ctrlWb_q    <= ctrlWb_d;
            illCnt_q    <= illCnt_d;
            illSticky_q <= illSticky_d;
        end
    end

    // Output mapping; the ALU op is zero-extended to the requested width.
    assign REGWRITE_E   = ctrlE_q.regwrite;
    assign MEMTOREG_E   = ctrlE_q.memtoreg;
    assign MEMWRITE_E   = ctrlE_q.memwrite;
    assign BRANCH_E     = ctrlE_q.branch;
    assign ALUSRC_E     = ctrlE_q.alusrc;
    assign REGDST_E     = ctrlE_q.regdst;
    assign ZEROEXT_E    = ctrlE_q.zeroext;
    assign ALUCONTROL_E = ALUCTRL_W'(ctrlE_q.alucontrol);
    assign REGWRITE_M   = ctrlM_q.regwrite;
    assign MEMTOREG_M   = ctrlM_q.memtoreg;
    assign MEMWRITE_M   = ctrlM_q.memwrite;
    assign BRANCH_M     = ctrlM_q.branch;
    assign PCSRC_M      = branchTaken;
    assign REGWRITE_WB  = ctrlWb_q.regwrite;
    assign MEMTOREG_WB  = ctrlWb_q.memtoreg;
    assign ILL_CNT      = illCnt_q;
    assign ILL_STICKY   = illSticky_q;

endmodule

// File: tb/tb_pipe_controller_hz.sv
// ---------------------------------------------------------------------------
// tb_pipe_controller_hz
//
// Self-checking bench for pipe_controller_hz built with ALUCTRL_W=4 (so the
// zero MSB of ALUCONTROL_E is visible) and CNT_W=2 (so saturation is quick).
// A decode table is streamed through the pipe with a scoreboard queue, then
// hand-written sequences cover reset, branch squash, HOLD/FLUSH_E priority,
// the illegal counter and the optional BNE opcode.
// ---------------------------------------------------------------------------
module tb_pipe_controller_hz;

    localparam int ALUCTRL_W = 4;
    localparam int CNT_W     = 2;
`ifdef PIPE_CTRL_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_ADI = 6'b001000;
    localparam logic [5:0] OP_ANI = 6'b001100;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;

    logic                 CLK = 1'b0;
    logic                 RESET;
    logic [5:0]           opcode;
    logic [5:0]           funct;
    logic                 ZERO_M;
    logic                 HOLD;
    logic                 FLUSH_E;
    logic                 JUMP_D;
    logic                 REGWRITE_E, MEMTOREG_E, MEMWRITE_E, BRANCH_E;
    logic                 ALUSRC_E, REGDST_E, ZEROEXT_E;
    logic [ALUCTRL_W-1:0] ALUCONTROL_E;
    logic                 REGWRITE_M, MEMTOREG_M, MEMWRITE_M, BRANCH_M;
    logic                 PCSRC_M;
    logic                 REGWRITE_WB, MEMTOREG_WB;
    logic [CNT_W-1:0]     ILL_CNT;
    logic                 ILL_STICKY;

    pipe_controller_hz #(.ALUCTRL_W(ALUCTRL_W), .CNT_W(CNT_W)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .opcode       (opcode),
        .funct        (funct),
        .ZERO_M       (ZERO_M),
        .HOLD         (HOLD),
        .FLUSH_E      (FLUSH_E),
        .JUMP_D       (JUMP_D),
        .REGWRITE_E   (REGWRITE_E),
        .MEMTOREG_E   (MEMTOREG_E),
        .MEMWRITE_E   (MEMWRITE_E),
        .BRANCH_E     (BRANCH_E),
        .ALUSRC_E     (ALUSRC_E),
        .REGDST_E     (REGDST_E),
        .ZEROEXT_E    (ZEROEXT_E),
        .ALUCONTROL_E (ALUCONTROL_E),
        .REGWRITE_M   (REGWRITE_M),
        .MEMTOREG_M   (MEMTOREG_M),
        .MEMWRITE_M   (MEMWRITE_M),
        .BRANCH_M     (BRANCH_M),
        .PCSRC_M      (PCSRC_M),
        .REGWRITE_WB  (REGWRITE_WB),
        .MEMTOREG_WB  (MEMTOREG_WB),
        .ILL_CNT      (ILL_CNT),
        .ILL_STICKY   (ILL_STICKY)
    );

    // Free-running clock, 10 time units per cycle
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic       rw, mr, mw, br, as, rd, zx;
        logic [2:0] alu;
        logic       ill, ne, jmp;
    } vec_t;

    int   testsRun  = 0;
    int   failCount = 0;
    vec_t tbl [18];
    vec_t sbQ [$];
    int   expCnt;
    logic expSticky;
    logic pendIll;

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn,
                                input logic [6:0] ctl, input logic [2:0] alu,
                                input logic ill, input logic ne, input logic jmp);
        vec_t v;
        v.op = op;
        v.fn = fn;
        {v.rw, v.mr, v.mw, v.br, v.as, v.rd, v.zx} = ctl;
        v.alu = alu;
        v.ill = ill;
        v.ne  = ne;
        v.jmp = jmp;
        return v;
    endfunction

    function automatic logic [15:0] eAct();
        return 16'({REGWRITE_E, MEMTOREG_E, MEMWRITE_E, BRANCH_E, ALUSRC_E,
                    REGDST_E, ZEROEXT_E, ALUCONTROL_E});
    endfunction

    function automatic logic [15:0] eExp(input vec_t v);
        return 16'({v.rw, v.mr, v.mw, v.br, v.as, v.rd, v.zx, 1'b0, v.alu});
    endfunction

    function automatic logic [15:0] mAct();
        return 16'({REGWRITE_M, MEMTOREG_M, MEMWRITE_M, BRANCH_M});
    endfunction

    function automatic logic [15:0] wbAct();
        return 16'({REGWRITE_WB, MEMTOREG_WB});
    endfunction

    function automatic logic [15:0] cntAct();
        return 16'({ILL_CNT, ILL_STICKY});
    endfunction

    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                                 input logic hold, input logic flushE);
        opcode  = op;
        funct   = fn;
        HOLD    = hold;
        FLUSH_E = flushE;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act,
                               input logic [15:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic doReset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    // Watchdog so the run always ends even if something stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        tbl[0]  = mk(OP_LW,  6'b100101, 7'b1100100, 3'b010, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(OP_R,   6'b100000, 7'b1000010, 3'b010, 1'b0, 1'b0, 1'b0);
        tbl[2]  = mk(OP_R,   6'b100010, 7'b1000010, 3'b110, 1'b0, 1'b0, 1'b0);
        tbl[3]  = mk(OP_R,   6'b100100, 7'b1000010, 3'b000, 1'b0, 1'b0, 1'b0);
        tbl[4]  = mk(OP_R,   6'b100101, 7'b1000010, 3'b001, 1'b0, 1'b0, 1'b0);
        tbl[5]  = mk(OP_R,   6'b101010, 7'b1000010, 3'b111, 1'b0, 1'b0, 1'b0);
        tbl[6]  = mk(OP_R,   6'b000001, 7'b0000010, 3'b000, 1'b1, 1'b0, 1'b0);
        tbl[7]  = mk(OP_SW,  6'b100010, 7'b0010100, 3'b010, 1'b0, 1'b0, 1'b0);
        tbl[8]  = mk(OP_BEQ, 6'b100000, 7'b0001000, 3'b110, 1'b0, 1'b0, 1'b0);
        tbl[9]  = mk(OP_ADI, 6'b101010, 7'b1000100, 3'b010, 1'b0, 1'b0, 1'b0);
        tbl[10] = mk(OP_ANI, 6'b100101, 7'b1000101, 3'b000, 1'b0, 1'b0, 1'b0);
        tbl[11] = mk(OP_ORI, 6'b100100, 7'b1000101, 3'b001, 1'b0, 1'b0, 1'b0);
        tbl[12] = mk(OP_J,   6'b100000, 7'b0000000, 3'b000, 1'b0, 1'b0, 1'b1);
        tbl[13] = mk(OP_BAD, 6'b100000, 7'b0000000, 3'b000, 1'b1, 1'b0, 1'b0);
        tbl[14] = BNE_EN ? mk(OP_BNE, 6'b000000, 7'b0001000, 3'b110, 1'b0, 1'b1, 1'b0)
                         : mk(OP_BNE, 6'b000000, 7'b0000000, 3'b000, 1'b1, 1'b0, 1'b0);
        tbl[15] = mk(OP_J,   6'b000000, 7'b0000000, 3'b000, 1'b0, 1'b0, 1'b1);
        tbl[16] = tbl[15];
        tbl[17] = tbl[15];

        // ---------------- power-on reset ----------------
        RESET  = 1'b1;
        ZERO_M = 1'b0;
        applyStimulus(OP_LW, 6'b000000, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("reset_e",   eAct(),   16'h0);
        checkOutput("reset_m",   mAct(),   16'h0);
        checkOutput("reset_wb",  wbAct(),  16'h0);
        checkOutput("reset_cnt", cntAct(), 16'h0);
        RESET = 1'b0;

        // ---------------- decode table through the scoreboard ----------------
        expCnt    = 0;
        expSticky = 1'b0;
        pendIll   = 1'b0;
        for (int i = 0; i < 18; i++) begin
            applyStimulus(tbl[i].op, tbl[i].fn, 1'b0, 1'b0);
            #1;
            checkOutput($sformatf("jump_d[%0d]", i), 16'(JUMP_D), 16'(tbl[i].jmp));
            sbQ.push_back(tbl[i]);
            tick();
            if (pendIll) begin
                if (expCnt < 3) expCnt++;
                expSticky = 1'b1;
            end
            pendIll = 1'b0;
            checkOutput($sformatf("e[%0d]", i), eAct(), eExp(sbQ[sbQ.size()-1]));
            if (sbQ.size() >= 2) begin
                ZERO_M = sbQ[sbQ.size()-2].ne;
                checkOutput($sformatf("m[%0d]", i), mAct(),
                            16'({sbQ[sbQ.size()-2].rw, sbQ[sbQ.size()-2].mr,
                                 sbQ[sbQ.size()-2].mw, sbQ[sbQ.size()-2].br}));
            end else begin
                ZERO_M = 1'b0;
            end
            #1;
            checkOutput($sformatf("pcsrc[%0d]", i), 16'(PCSRC_M), 16'h0);
            if (sbQ.size() >= 3) begin
                checkOutput($sformatf("wb[%0d]", i), wbAct(),
                            16'({sbQ[0].rw, sbQ[0].mr}));
                pendIll = sbQ[0].ill;
                void'(sbQ.pop_front());
            end
            checkOutput($sformatf("cnt[%0d]", i), cntAct(),
                        16'({2'(expCnt), expSticky}));
        end
        sbQ.delete();
        ZERO_M = 1'b0;

        // ---------------- reset mid-stream, overriding HOLD ----------------
        applyStimulus(OP_LW, 6'b000000, 1'b0, 1'b0);
        tick();
        applyStimulus(OP_ORI, 6'b000000, 1'b1, 1'b1);
        RESET = 1'b1;
        tick();
        checkOutput("midreset1_e",   eAct(),   16'h0);
        checkOutput("midreset1_cnt", cntAct(), 16'h0);
        tick();
        RESET = 1'b0;
        checkOutput("midreset2_e",   eAct(),   16'h0);
        checkOutput("midreset2_m",   mAct(),   16'h0);
        checkOutput("midreset2_wb",  wbAct(),  16'h0);
        checkOutput("midreset2_cnt", cntAct(), 16'h0);

        // ---------------- taken BEQ squashes ADDI and SW ----------------
        applyStimulus(OP_BEQ, 6'b000000, 1'b0, 1'b0);
        tick();
        applyStimulus(OP_ADI, 6'b000000, 1'b0, 1'b0);
        tick();
        ZERO_M = 1'b1;
        #1;
        checkOutput("br_pcsrc_taken", 16'(PCSRC_M), 16'h1);
        checkOutput("br_addi_in_e",   eAct(), 16'b1000100_0010);
        applyStimulus(OP_SW, 6'b000000, 1'b0, 1'b0);
        tick();
        ZERO_M = 1'b0;
        #1;
        checkOutput("br_e_squashed",  eAct(),   16'h0);
        checkOutput("br_m_squashed",  mAct(),   16'h0);
        checkOutput("br_pcsrc_after", 16'(PCSRC_M), 16'h0);

        // ---------------- HOLD beats FLUSH_E, then FLUSH_E alone ----------------
        applyStimulus(OP_LW, 6'b000000, 1'b0, 1'b0);
        tick();
        applyStimulus(OP_R, 6'b100000, 1'b0, 1'b0);
        tick();
        applyStimulus(OP_ORI, 6'b000000, 1'b0, 1'b0);
        tick();
        applyStimulus(OP_SW, 6'b000000, 1'b1, 1'b1);
        tick();
        checkOutput("hold_e",  eAct(),  16'b1000101_0001);
        checkOutput("hold_m",  mAct(),  16'b1000);
        checkOutput("hold_wb", wbAct(), 16'b11);
        applyStimulus(OP_SW, 6'b000000, 1'b0, 1'b1);
        tick();
        checkOutput("flush_e",  eAct(),  16'h0);
        checkOutput("flush_m",  mAct(),  16'b1000);
        checkOutput("flush_wb", wbAct(), 16'b10);

        // ---------------- illegal counter saturation ----------------
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(OP_BAD, 6'b000000, 1'b0, 1'b1);
            tick();
        end
        checkOutput("ill_bubbles_nocount", cntAct(), 16'b000);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(OP_BAD, 6'b000000, 1'b0, 1'b0);
            tick();
        end
        checkOutput("ill_cnt_1", cntAct(), 16'b011);
        applyStimulus(OP_R, 6'b000001, 1'b0, 1'b0);
        tick();
        checkOutput("ill_cnt_2", cntAct(), 16'b101);
        applyStimulus(OP_J, 6'b000000, 1'b1, 1'b0);
        tick();
        checkOutput("ill_hold_cnt", cntAct(), 16'b101);
        checkOutput("ill_hold_e",   eAct(),   16'b0000010_0000);
        applyStimulus(OP_J, 6'b000000, 1'b0, 1'b0);
        tick();
        checkOutput("ill_cnt_3", cntAct(), 16'b111);
        tick();
        checkOutput("ill_rbad_wb_norw", 16'(REGWRITE_WB), 16'h0);
        checkOutput("ill_cnt_sat",      cntAct(), 16'b111);
        tick();
        checkOutput("ill_cnt_sat2", cntAct(), 16'b111);

        // ---------------- BNE (optional opcode) ----------------
        doReset();
        ZERO_M = 1'b0;
        applyStimulus(OP_BNE, 6'b000000, 1'b0, 1'b0);
        tick();
        applyStimulus(OP_J, 6'b000000, 1'b0, 1'b0);
        tick();
        #1;
        checkOutput("bne_pcsrc", 16'(PCSRC_M), 16'(BNE_EN));
        tick();
        tick();
        checkOutput("bne_cnt", cntAct(), BNE_EN ? 16'b000 : 16'b011);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
